// File: rtl/aes_job_ctrl.sv
// aes_job_ctrl
// Queued encrypt/decrypt job controller sitting in front of the single-shot
// `encryption` and `decryption` cores. Jobs {mode, tag, key, data} are buffered
// in a DEPTH-entry FIFO, run one at a time on the selected core, and returned
// as {tag, result, err}. A job whose core never reports done within TIMEOUT
// cycles is aborted with err=1 and counted in a saturating error counter.
//
// Ports
//   clock, rst                  rising-edge clock, synchronous active-high reset
//   i_in_valid / o_in_ready     job input handshake (o_in_ready = FIFO not full)
//   i_in_mode/tag/key/data      job fields (mode 1 = encrypt, 0 = decrypt)
//   o_out_valid / i_out_ready   result output handshake
//   o_out_tag/data/err          completed job tag, core result (0 on error), timeout flag
//   o_core_key/o_core_data      operands to both cores
//   o_enc_start/o_dec_start     level "inputs loaded" strobes to each core
//   o_core_rst                  reset to both cores
//   i_enc_done/result, i_dec_done/result   core completion and result
//   o_fifo_level                FIFO occupancy
//   o_busy                      controller not idle
//   o_err_count                 saturating timeout count
//
// State | meaning
//   IDLE   | cores out of reset, waiting for a queued job
//   LAUNCH | pop FIFO head, present operands, raise the selected start line
//   WAIT   | wait for the selected core's done flag or the timeout
//   OUT    | hold the result until the consumer takes it
//   CLEAR  | one-cycle core reset and operand clear before the next job
module aes_job_ctrl #(
    parameter int DATA_W  = 128,
    parameter int TAG_W   = 4,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                         clock,
    input  logic                         rst,
    input  logic                         i_in_valid,
    output logic                         o_in_ready,
    input  logic                         i_in_mode,
    input  logic [TAG_W-1:0]             i_in_tag,
    input  logic [DATA_W-1:0]            i_in_key,
    input  logic [DATA_W-1:0]            i_in_data,
    output logic                         o_out_valid,
    input  logic                         i_out_ready,
    output logic [TAG_W-1:0]             o_out_tag,
    output logic [DATA_W-1:0]            o_out_data,
    output logic                         o_out_err,
    output logic [DATA_W-1:0]            o_core_key,
    output logic [DATA_W-1:0]            o_core_data,
    output logic                         o_enc_start,
    output logic                         o_dec_start,
    output logic                         o_core_rst,
    input  logic                         i_enc_done,
    input  logic [DATA_W-1:0]            i_enc_result,
    input  logic                         i_dec_done,
    input  logic [DATA_W-1:0]            i_dec_result,
    output logic [$clog2(DEPTH):0]       o_fifo_level,
    output logic                         o_busy,
    output logic [7:0]                   o_err_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int TMR_W = $clog2(TIMEOUT);

    typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_OUT, S_CLEAR} state_t;

    logic                r_mem_mode [DEPTH];
    logic [TAG_W-1:0]    r_mem_tag  [DEPTH];
    logic [DATA_W-1:0]   r_mem_key  [DEPTH];
    logic [DATA_W-1:0]   r_mem_data [DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr, r_rd_ptr;
    logic [LVL_W-1:0]    r_level;
    logic                r_in_ready;

    state_t              r_state, w_state_nxt;
    logic                r_mode, w_mode_nxt;
    logic [TAG_W-1:0]    r_tag, w_tag_nxt;
    logic [TMR_W-1:0]    r_timer, w_timer_nxt;
    logic                r_out_valid, w_out_valid_nxt;
    logic [TAG_W-1:0]    r_out_tag, w_out_tag_nxt;
    logic [DATA_W-1:0]   r_out_data, w_out_data_nxt;
    logic                r_out_err, w_out_err_nxt;
    logic [DATA_W-1:0]   r_core_key, w_core_key_nxt;
    logic [DATA_W-1:0]   r_core_data, w_core_data_nxt;
    logic                r_enc_start, w_enc_start_nxt;
    logic                r_dec_start, w_dec_start_nxt;
    logic                r_core_rst, w_core_rst_nxt;
    logic                r_busy;
    logic [7:0]          r_err_count, w_err_count_nxt;

    logic                w_push, w_pop, w_done;
    logic [DATA_W-1:0]   w_result;
    logic [LVL_W-1:0]    w_level_nxt;

    // Ready is taken from the registered full flag, so a pop in the same
    // cycle never lets a push into a full FIFO.
    assign w_push      = i_in_valid && r_in_ready;
    assign w_level_nxt = r_level + LVL_W'(w_push) - LVL_W'(w_pop);

    // Only the selected core is observed; the idle core's flags are ignored.
    assign w_done   = r_mode ? i_enc_done   : i_dec_done;
    assign w_result = r_mode ? i_enc_result : i_dec_result;

    always_comb begin
        w_state_nxt     = r_state;
        w_mode_nxt      = r_mode;
        w_tag_nxt       = r_tag;
        w_timer_nxt     = r_timer;
        w_out_valid_nxt = r_out_valid;
        w_out_tag_nxt   = r_out_tag;
        w_out_data_nxt  = r_out_data;
        w_out_err_nxt   = r_out_err;
        w_core_key_nxt  = r_core_key;
        w_core_data_nxt = r_core_data;
        w_enc_start_nxt = r_enc_start;
        w_dec_start_nxt = r_dec_start;
        w_core_rst_nxt  = r_core_rst;
        w_err_count_nxt = r_err_count;
        w_pop           = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_core_rst_nxt  = 1'b0;
                w_enc_start_nxt = 1'b0;
                w_dec_start_nxt = 1'b0;
                if (r_level != '0) w_state_nxt = S_LAUNCH;
            end
            S_LAUNCH: begin
                w_pop           = 1'b1;
                w_core_key_nxt  = r_mem_key[r_rd_ptr];
                w_core_data_nxt = r_mem_data[r_rd_ptr];
                w_mode_nxt      = r_mem_mode[r_rd_ptr];
                w_tag_nxt       = r_mem_tag[r_rd_ptr];
                w_enc_start_nxt = r_mem_mode[r_rd_ptr];
                w_dec_start_nxt = !r_mem_mode[r_rd_ptr];
                w_timer_nxt     = '0;
                w_state_nxt     = S_WAIT;
            end
            S_WAIT: begin
                if (w_done) begin
                    w_out_data_nxt  = w_result;
                    w_out_err_nxt   = 1'b0;
                    w_out_tag_nxt   = r_tag;
                    w_out_valid_nxt = 1'b1;
                    w_state_nxt     = S_OUT;
                end else if (r_timer == TMR_W'(TIMEOUT - 1)) begin
                    w_out_data_nxt  = '0;
                    w_out_err_nxt   = 1'b1;
                    w_out_tag_nxt   = r_tag;
                    w_out_valid_nxt = 1'b1;
                    if (r_err_count != 8'hFF) w_err_count_nxt = r_err_count + 8'd1;
                    w_state_nxt     = S_OUT;
                end else begin
                    w_timer_nxt = r_timer + TMR_W'(1);
                end
            end
            S_OUT: begin
                if (i_out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    w_state_nxt     = S_CLEAR;
                end
            end
            S_CLEAR: begin
                w_enc_start_nxt = 1'b0;
                w_dec_start_nxt = 1'b0;
                w_core_key_nxt  = '0;
                w_core_data_nxt = '0;
                w_core_rst_nxt  = 1'b1;
                w_state_nxt     = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FIFO storage carries no reset; only the pointers and level are flushed.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem_mode[r_wr_ptr] <= i_in_mode;
            r_mem_tag[r_wr_ptr]  <= i_in_tag;
            r_mem_key[r_wr_ptr]  <= i_in_key;
            r_mem_data[r_wr_ptr] <= i_in_data;
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
            r_mode      <= 1'b0;
            r_tag       <= '0;
            r_timer     <= '0;
            r_out_valid <= 1'b0;
            r_out_tag   <= '0;
            r_out_data  <= '0;
            r_out_err   <= 1'b0;
            r_core_key  <= '0;
            r_core_data <= '0;
            r_enc_start <= 1'b0;
            r_dec_start <= 1'b0;
            r_core_rst  <= 1'b1;
            r_busy      <= 1'b0;
            r_err_count <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_level     <= w_level_nxt;
            r_in_ready  <= (w_level_nxt != LVL_W'(DEPTH));
            r_state     <= w_state_nxt;
            r_mode      <= w_mode_nxt;
            r_tag       <= w_tag_nxt;
            r_timer     <= w_timer_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_tag   <= w_out_tag_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_err   <= w_out_err_nxt;
            r_core_key  <= w_core_key_nxt;
            r_core_data <= w_core_data_nxt;
            r_enc_start <= w_enc_start_nxt;
            r_dec_start <= w_dec_start_nxt;
            r_core_rst  <= w_core_rst_nxt;
            r_busy      <= (w_state_nxt != S_IDLE);
            r_err_count <= w_err_count_nxt;
        end
    end

    assign o_in_ready   = r_in_ready;
    assign o_out_valid  = r_out_valid;
    assign o_out_tag    = r_out_tag;
    assign o_out_data   = r_out_data;
    assign o_out_err    = r_out_err;
    assign o_core_key   = r_core_key;
    assign o_core_data  = r_core_data;
    assign o_enc_start  = r_enc_start;
    assign o_dec_start  = r_dec_start;
    assign o_core_rst   = r_core_rst;
    assign o_fifo_level = r_level;
    assign o_busy       = r_busy;
    assign o_err_count  = r_err_count;

endmodule

// File: tb/tb_aes_job_ctrl.sv
// Testbench for aes_job_ctrl: behavioural core stubs, randomized jobs and a
// scoreboard that checks results in push order, plus directed timing cases.
module tb_aes_job_ctrl;
    localparam int DW = 128;
    localparam int TW = 4;
    localparam int DEPTH = 4;
    localparam int TO = 64;
    localparam int LW = $clog2(DEPTH) + 1;

    localparam logic [DW-1:0] FK      = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [DW-1:0] FP      = 128'h00112233445566778899aabbccddeeff;
    localparam logic [DW-1:0] FC      = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [DW-1:0] K_STUCK = 128'hdeadbeef_0bad_f00d_dead_beef0badf00d;

    logic clock = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0, in_ready, in_mode = 1'b0;
    logic [TW-1:0] in_tag = '0;
    logic [DW-1:0] in_key = '0, in_data = '0;
    logic out_valid, out_ready = 1'b0, out_err;
    logic [TW-1:0] out_tag;
    logic [DW-1:0] out_data, core_key, core_data;
    logic enc_start, dec_start, core_rst;
    logic enc_done = 1'b0, dec_done = 1'b0;
    logic [DW-1:0] enc_result = '0, dec_result = '0;
    logic [LW-1:0] fifo_level;
    logic busy;
    logic [7:0] err_count;

    aes_job_ctrl #(.DATA_W(DW), .TAG_W(TW), .DEPTH(DEPTH), .TIMEOUT(TO)) dut (
        .clock(clock), .rst(rst),
        .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_mode(in_mode),
        .i_in_tag(in_tag), .i_in_key(in_key), .i_in_data(in_data),
        .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_tag(out_tag),
        .o_out_data(out_data), .o_out_err(out_err),
        .o_core_key(core_key), .o_core_data(core_data),
        .o_enc_start(enc_start), .o_dec_start(dec_start), .o_core_rst(core_rst),
        .i_enc_done(enc_done), .i_enc_result(enc_result),
        .i_dec_done(dec_done), .i_dec_result(dec_result),
        .o_fifo_level(fifo_level), .o_busy(busy), .o_err_count(err_count)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: bound expired at cycle %0d", name, cyc);
    endtask

    // Stub core transfer functions: the real cipher for the FIPS-197 vector,
    // a simple distinguishable mapping for everything else.
    function automatic logic [DW-1:0] f_enc(input logic [DW-1:0] k, input logic [DW-1:0] d);
        if (k == FK && d == FP) return FC;
        return d ^ {k[63:0], k[127:64]} ^ 128'h5a5a5a5a_5a5a5a5a_5a5a5a5a_5a5a5a5a;
    endfunction

    function automatic logic [DW-1:0] f_dec(input logic [DW-1:0] k, input logic [DW-1:0] d);
        if (k == FK && d == FC) return FP;
        return d + k;
    endfunction

    function automatic logic [DW-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Core stubs: done after a random latency while their own start is high,
    // never for the stuck key; noise on done/result when not started.
    int enc_cnt = 0, enc_lat = 1, dec_cnt = 0, dec_lat = 1;
    always @(negedge clock) begin
        if (core_rst) begin
            enc_done = 1'b0; enc_cnt = 0;
        end else if (enc_start) begin
            if (enc_cnt == 0) enc_lat = $urandom_range(1, 12);
            enc_cnt++;
            if (core_key != K_STUCK && enc_cnt >= enc_lat) begin
                enc_done = 1'b1; enc_result = f_enc(core_key, core_data);
            end else begin
                enc_done = 1'b0; enc_result = rnd128();
            end
        end else begin
            enc_cnt = 0; enc_done = 1'($urandom_range(0, 1)); enc_result = rnd128();
        end
        if (core_rst) begin
            dec_done = 1'b0; dec_cnt = 0;
        end else if (dec_start) begin
            if (dec_cnt == 0) dec_lat = $urandom_range(1, 12);
            dec_cnt++;
            if (core_key != K_STUCK && dec_cnt >= dec_lat) begin
                dec_done = 1'b1; dec_result = f_dec(core_key, core_data);
            end else begin
                dec_done = 1'b0; dec_result = rnd128();
            end
        end else begin
            dec_cnt = 0; dec_done = 1'($urandom_range(0, 1)); dec_result = rnd128();
        end
    end

    typedef struct {
        logic [TW-1:0] tag;
        logic [DW-1:0] data;
        logic          err;
    } exp_t;
    exp_t sb_q[$];
    exp_t mon_e;
    int exp_timeouts = 0;

    // Monitor: drives out_ready and checks each result at its handshake.
    int ready_mode = 1;
    logic held = 1'b0;
    logic [DW-1:0] held_data;
    logic [TW-1:0] held_tag;
    always @(negedge clock) begin
        if (rst) begin
            out_ready = 1'b0;
            held = 1'b0;
        end else begin
            case (ready_mode)
                0: out_ready = 1'b0;
                1: out_ready = 1'b1;
                default: out_ready = ($urandom_range(0, 2) != 0);
            endcase
            if (out_valid) begin
                if (held) begin
                    check("hold_data", out_data, held_data);
                    check("hold_tag", DW'(out_tag), DW'(held_tag));
                end
                held = 1'b1;
                held_data = out_data;
                held_tag = out_tag;
                if (out_ready) begin
                    if (sb_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_output: tag %0d data %h with empty scoreboard", out_tag, out_data);
                    end else begin
                        mon_e = sb_q.pop_front();
                        check("out_tag", DW'(out_tag), DW'(mon_e.tag));
                        check("out_data", out_data, mon_e.data);
                        check("out_err", DW'(out_err), DW'(mon_e.err));
                    end
                    held = 1'b0;
                end
            end else begin
                held = 1'b0;
            end
        end
    end

    // Offers a job and returns right after the edge that accepted it; in_valid
    // stays high so consecutive calls push on consecutive edges.
    task automatic push_job(input logic mode, input logic [TW-1:0] tag,
                            input logic [DW-1:0] key, input logic [DW-1:0] data);
        exp_t e;
        int n = 0;
        @(negedge clock);
        in_valid = 1'b1; in_mode = mode; in_tag = tag; in_key = key; in_data = data;
        while (!in_ready && n < 3000) begin
            @(negedge clock);
            n++;
        end
        if (!in_ready) begin
            fail_now("push_wait");
            in_valid = 1'b0;
            return;
        end
        @(posedge clock);
        e.tag = tag;
        e.err = (key == K_STUCK);
        e.data = e.err ? '0 : (mode ? f_enc(key, data) : f_dec(key, data));
        if (e.err) exp_timeouts++;
        sb_q.push_back(e);
    endtask

    task automatic idle_in();
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sb_q.size() != 0 || busy || fifo_level != 0) && n < 6000) begin
            @(negedge clock);
            n++;
        end
        if (n >= 6000) fail_now("drain");
    endtask

    int t0, t1, n;

    initial begin
        // Reset state
        repeat (2) @(negedge clock);
        check("rst_out_valid", DW'(out_valid), '0);
        check("rst_out_data", out_data, '0);
        check("rst_core_rst", DW'(core_rst), DW'(1));
        check("rst_starts", DW'({enc_start, dec_start}), '0);
        check("rst_fifo_level", DW'(fifo_level), '0);
        check("rst_busy", DW'(busy), '0);
        check("rst_err_count", DW'(err_count), '0);
        rst = 1'b0;

        // FIPS-197 encrypt then decrypt
        ready_mode = 1;
        push_job(1'b1, 4'd3, FK, FP);
        push_job(1'b0, 4'd5, FK, FC);
        idle_in();
        wait_drain();

        // Timeout: stuck core, latency, core_rst pulse, error count
        push_job(1'b1, 4'd9, K_STUCK, rnd128());
        idle_in();
        n = 0;
        while (!enc_start && n < 20) begin @(negedge clock); n++; end
        t0 = cyc;
        n = 0;
        while (!out_valid && n < 200) begin @(negedge clock); n++; end
        t1 = cyc;
        if (!out_valid) fail_now("timeout_wait");
        else begin
            check("timeout_latency", DW'(t1 - t0), DW'(TO));
            @(negedge clock);
            check("clear_core_rst_h0", DW'(core_rst), '0);
            @(negedge clock);
            check("clear_core_rst_h1", DW'(core_rst), DW'(1));
            @(negedge clock);
            check("clear_core_rst_h2", DW'(core_rst), '0);
            check("timeout_err_count", DW'(err_count), DW'(1));
        end
        wait_drain();

        // Back-pressure: 5 pushes with consumer stalled, then 10-cycle hold
        ready_mode = 0;
        for (int i = 0; i < 5; i++) push_job(1'($urandom_range(0, 1)), TW'(i), rnd128(), rnd128());
        idle_in();
        check("full_in_ready", DW'(in_ready), '0);
        check("full_level", DW'(fifo_level), DW'(DEPTH));
        n = 0;
        while (!out_valid && n < 100) begin @(negedge clock); n++; end
        if (!out_valid) fail_now("hold_wait");
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check("hold_level", DW'(fifo_level), DW'(DEPTH));
            check("hold_valid", DW'(out_valid), DW'(1));
        end
        ready_mode = 1;
        wait_drain();

        // Randomized traffic with random back-pressure and some stuck jobs
        ready_mode = 2;
        for (int i = 0; i < 40; i++) begin
            push_job(1'($urandom_range(0, 1)), TW'($urandom),
                     ($urandom_range(0, 9) == 0) ? K_STUCK : rnd128(), rnd128());
            if ($urandom_range(0, 3) == 0) begin
                idle_in();
                repeat ($urandom_range(0, 6)) @(negedge clock);
            end
        end
        idle_in();
        wait_drain();
        check("rand_err_count", DW'(err_count), DW'(exp_timeouts > 255 ? 255 : exp_timeouts));

        // Reset while a job is in WAIT with more queued
        ready_mode = 1;
        push_job(1'b1, 4'd1, K_STUCK, rnd128());
        push_job(1'b0, 4'd2, rnd128(), rnd128());
        push_job(1'b1, 4'd3, rnd128(), rnd128());
        idle_in();
        n = 0;
        while (!(enc_start || dec_start) && n < 20) begin @(negedge clock); n++; end
        repeat (3) @(negedge clock);
        rst = 1'b1;
        @(negedge clock);
        check("midrst_level", DW'(fifo_level), '0);
        check("midrst_busy", DW'(busy), '0);
        check("midrst_core_rst", DW'(core_rst), DW'(1));
        check("midrst_out_valid", DW'(out_valid), '0);
        sb_q.delete();
        exp_timeouts = 0;
        rst = 1'b0;
        push_job(1'b1, 4'd7, FK, FP);
        idle_in();
        wait_drain();
        check("final_err_count", DW'(err_count), DW'(exp_timeouts));
        check("final_pending", DW'(sb_q.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
